// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack data-bus initiator with a pipeline stall.
// Optional misalignment trap is built when LSU_MISALIGN_EN is defined.
module mem_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_int_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_op_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [31:0] exception_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_req_o,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic [31:0] exception_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      state;
  logic        is_ld, is_st, sgn;
  logic [1:0]  sz;
  logic [1:0]  a;
  logic        misal, launch;
  logic [3:0]  sel;
  logic [31:0] wdata;

  logic        ld_q, sgn_q, flushed_q;
  logic [1:0]  sz_q, off_q;
  logic [31:0] ld_res_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] fmt;

  // store flag is informational; the operation comes from mem_op_i
  logic unused_we;
  assign unused_we = mem_we_i;

  assign a = mem_addr_i[1:0];

  // operation decode
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sgn   = 1'b0;
    sz    = SZ_W;
    unique case (mem_op_i)
      4'd1: begin is_ld = 1'b1; sgn = 1'b1; sz = SZ_B; end
      4'd2: begin is_ld = 1'b1; sgn = 1'b1; sz = SZ_H; end
      4'd3: begin is_ld = 1'b1; sz = SZ_W; end
      4'd4: begin is_ld = 1'b1; sz = SZ_B; end
      4'd5: begin is_ld = 1'b1; sz = SZ_H; end
      4'd6: begin is_st = 1'b1; sz = SZ_B; end
      4'd7: begin is_st = 1'b1; sz = SZ_H; end
      4'd8: begin is_st = 1'b1; sz = SZ_W; end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_EN
  assign misal = (sz == SZ_H && a[0]) ||
                 (sz == SZ_W && a != 2'd0);
`else
  assign misal = 1'b0;
`endif

  assign launch = (state == IDLE) && (is_ld || is_st) &&
                  !flush_int_i && !misal;

  assign stall_req_o = !rst_i &&
                       ((state == BUSY) || launch);

  // byte-lane enables and lane-replicated store data
  always_comb begin
    sel   = 4'b1111;
    wdata = mem_data_i;
    unique case (sz)
      SZ_B: begin
        sel   = 4'b0001 << a;
        wdata = {4{mem_data_i[7:0]}};
      end
      SZ_H: begin
        sel   = a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // align and extend the returned read word
  always_comb begin
    byte_v = bus_rdata_i[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    unique case (sz_q)
      SZ_B:    fmt = sgn_q ? {{24{byte_v[7]}}, byte_v}
                           : {24'b0, byte_v};
      SZ_H:    fmt = sgn_q ? {{16{half_v[15]}}, half_v}
                           : {16'b0, half_v};
      default: fmt = bus_rdata_i;
    endcase
  end

  // access sequencer with registered bus outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      ld_res_q    <= '0;
      ld_q        <= 1'b0;
      sgn_q       <= 1'b0;
      sz_q        <= SZ_W;
      off_q       <= 2'd0;
      flushed_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (launch) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_st;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_sel_o   <= sel;
            bus_wdata_o <= wdata;
            ld_q        <= is_ld;
            sgn_q       <= sgn;
            sz_q        <= sz;
            off_q       <= a;
            flushed_q   <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (flush_int_i) flushed_q <= 1'b1;
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            ld_res_q  <= fmt;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // write-back fields towards MEM/WB
  always_comb begin
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = reg_we_i;
    reg_wdata_o = reg_wdata_i;
    exception_o = exception_i;
    if (state == IDLE && misal) begin
      reg_we_o    = 1'b0;
      exception_o = exception_i |
                    (is_ld ? 32'h10 : 32'h40);
    end
    if (state == DONE) begin
      if (ld_q) reg_wdata_o = ld_res_q;
      if (flushed_q || flush_int_i) reg_we_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu against a byte-arithmetic
// reference model of lanes, replication and load extension.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic        we_in = 1'b0;
  logic [3:0]  op = '0;
  logic [4:0]  wa = '0;
  logic        rwe = 1'b0;
  logic [31:0] rwd = '0, exc = '0;
  logic        breq, bwe, ack = 1'b0;
  logic [31:0] baddr, bwdata, brdata = '0;
  logic [3:0]  bsel;
  logic        stall;
  logic [4:0]  wa_o;
  logic        rwe_o;
  logic [31:0] rwd_o, exc_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk_i(clk), .rst_i(rst), .flush_int_i(flush),
    .mem_addr_i(addr), .mem_data_i(data), .mem_we_i(we_in),
    .mem_op_i(op), .reg_waddr_i(wa), .reg_we_i(rwe),
    .reg_wdata_i(rwd), .exception_i(exc),
    .bus_req_o(breq), .bus_we_o(bwe), .bus_addr_o(baddr),
    .bus_sel_o(bsel), .bus_wdata_o(bwdata),
    .bus_ack_i(ack), .bus_rdata_i(brdata),
    .stall_req_o(stall), .reg_waddr_o(wa_o),
    .reg_we_o(rwe_o), .reg_wdata_o(rwd_o),
    .exception_o(exc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] o);
    if (o == 1 || o == 4 || o == 6) return 1;
    if (o == 2 || o == 5 || o == 7) return 2;
    return 4;
  endfunction

  function automatic bit is_load(input logic [3:0] o);
    return o >= 1 && o <= 5;
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] o,
                                       input logic [31:0] ad);
    int n = nbytes(o);
    int lo = int'(ad % 4) - int'(ad % 4) % n;
    return 4'(((1 << n) - 1) << lo);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] o,
                                          input logic [31:0] d);
    int n = nbytes(o);
    longint unsigned part = longint'(d) % (64'd1 << (8 * n));
    longint unsigned r = 0;
    for (int k = 0; k < 4 / n; k++)
      r += part << (8 * n * k);
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] o,
                                         input logic [31:0] ad,
                                         input logic [31:0] rd);
    int n = nbytes(o);
    int lo = int'(ad % 4) - int'(ad % 4) % n;
    longint v = (longint'(rd) >> (8 * lo)) % (64'sd1 << (8 * n));
    longint r;
    if ((o == 1 || o == 2) && v >= (64'sd1 << (8 * n - 1)))
      v = v - (64'sd1 << (8 * n));
    r = v;
    return r[31:0];
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic [3:0] o, input logic [31:0] ad,
                           input logic [31:0] d, input logic [31:0] rd,
                           input int waits, input bit fl,
                           input logic [4:0] w_a, input bit w_e,
                           input logic [31:0] w_d, input string nm);
    int stalls = 0;
    nxt();
    op = o; addr = ad; data = d; we_in = !is_load(o);
    wa = w_a; rwe = w_e; rwd = w_d; exc = $urandom;
    flush = 1'b0; ack = 1'b0;
    #1;
    chk({nm, ".launch_stall"}, 32'(stall), 32'd1);
    chk({nm, ".idle_exc"}, exc_o, exc);
    if (stall) stalls++;
    nxt();
    for (int i = 0; i <= waits; i++) begin
      chk({nm, ".req"}, 32'(breq), 32'd1);
      chk({nm, ".addr"}, baddr, {ad[31:2], 2'b00});
      chk({nm, ".sel"}, 32'(bsel), 32'(m_sel(o, ad)));
      chk({nm, ".we"}, 32'(bwe), 32'(!is_load(o)));
      if (!is_load(o))
        chk({nm, ".wdata"}, bwdata, m_wdata(o, d));
      if (stall) stalls++;
      data = ~d;
      flush = fl && i == 0;
      ack = i == waits;
      brdata = (i == waits) ? rd : $urandom;
      nxt();
    end
    ack = 1'b0; flush = 1'b0; data = d;
    brdata = $urandom;
    #1;
    chk({nm, ".done_stall"}, 32'(stall), 32'd0);
    chk({nm, ".done_req"}, 32'(breq), 32'd0);
    chk({nm, ".stall_cycles"}, stalls, waits + 2);
    chk({nm, ".rwe"}, 32'(rwe_o), 32'(w_e && !fl));
    chk({nm, ".rwa"}, 32'(wa_o), 32'(w_a));
    chk({nm, ".rwd"}, rwd_o, is_load(o) ? m_load(o, ad, rd) : w_d);
  endtask

  initial begin
    logic [3:0]  o;
    logic [31:0] ad;
    int          n;

    op = 4'd3; addr = 32'h40;
    repeat (2) nxt();
    chk("rst.req", 32'(breq), 32'd0);
    chk("rst.we", 32'(bwe), 32'd0);
    chk("rst.addr", baddr, 32'd0);
    chk("rst.sel", 32'(bsel), 32'd0);
    chk("rst.wdata", bwdata, 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    rst = 1'b0; op = 4'd0;

    do_access(4'd8, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0,
              5'd0, 0, 32'h0, "sw");
    do_access(4'd1, 32'h203, 32'h0, 32'h80FF1234, 0, 0,
              5'd7, 1, 32'h5555, "lb");
    chk("lb.value", rwd_o, 32'hFFFFFF80);
    do_access(4'd4, 32'h203, 32'h0, 32'h80FF1234, 1, 0,
              5'd8, 1, 32'h5555, "lbu");
    chk("lbu.value", rwd_o, 32'h00000080);
    do_access(4'd7, 32'h2, 32'h0000ABCD, 32'h0, 0, 0,
              5'd0, 0, 32'h0, "sh");
    chk("sh.sel", 32'(bsel), 32'hC);
    chk("sh.wdata", bwdata, 32'hABCDABCD);
    do_access(4'd3, 32'h300, 32'h0, 32'hCAFEF00D, 3, 1,
              5'd9, 1, 32'h0, "flush");
    nxt();
    op = 4'd0; rwe = 1'b1; wa = 5'd3; rwd = 32'h1234; exc = 32'h8;
    #1;
    chk("flush.idle_stall", 32'(stall), 32'd0);
    chk("nop.rwe", 32'(rwe_o), 32'd1);
    chk("nop.rwd", rwd_o, 32'h1234);
    chk("nop.exc", exc_o, 32'h8);

    ack = 1'b1; op = 4'd12;
    nxt();
    ack = 1'b0;
    #1;
    chk("stray_ack.req", 32'(breq), 32'd0);
    chk("op12.stall", 32'(stall), 32'd0);

    op = 4'd1; addr = 32'h10; flush = 1'b1;
    #1;
    chk("idle_flush.stall", 32'(stall), 32'd0);
    nxt();
    flush = 1'b0; op = 4'd0;
    #1;
    chk("idle_flush.req", 32'(breq), 32'd0);

`ifdef LSU_MISALIGN_EN
    op = 4'd3; addr = 32'h101; rwe = 1'b1; exc = 32'h1;
    #1;
    chk("mis.stall", 32'(stall), 32'd0);
    chk("mis.rwe", 32'(rwe_o), 32'd0);
    chk("mis.exc", exc_o, 32'h11);
    op = 4'd8;
    #1;
    chk("mis_st.exc", exc_o, 32'h41);
    nxt();
    chk("mis.req", 32'(breq), 32'd0);
    op = 4'd0;
`else
    do_access(4'd3, 32'h101, 32'h0, 32'h89ABCDEF, 0, 0,
              5'd4, 1, 32'h0, "mis_off");
`endif

    do_access(4'd3, 32'h480, 32'h0, 32'h1, 2, 0,
              5'd5, 1, 32'h0, "pre_rst");
    nxt();
    op = 4'd3; addr = 32'h500; ack = 1'b0;
    nxt();
    chk("rst_busy.req_before", 32'(breq), 32'd1);
    rst = 1'b1;
    nxt();
    chk("rst_busy.req", 32'(breq), 32'd0);
    chk("rst_busy.addr", baddr, 32'd0);
    chk("rst_busy.sel", 32'(bsel), 32'd0);
    chk("rst_busy.wdata", bwdata, 32'd0);
    chk("rst_busy.we", 32'(bwe), 32'd0);
    chk("rst_busy.stall", 32'(stall), 32'd0);
    rst = 1'b0; op = 4'd0;

    for (int t = 0; t < 24; t++) begin
      o = 4'($urandom_range(1, 8));
      ad = $urandom;
      n = nbytes(o);
      ad = ad - ad % n;
      do_access(o, ad, $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3) == 0, 5'($urandom),
                $urandom_range(0, 1) == 1, $urandom, "rnd");
    end

    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the interrupt-capable RV32 pipeline. It sits downstream of the EXE/MEM pipeline register and consumes its memory-request fields. It acts as initiator on the single-port data bus with a req/ack handshake. It stalls the pipeline while an access is outstanding and hands the write-back fields (with aligned, sign-extended load data) to the MEM/WB register.

## Interface
Parameters:
- none; widths come from `ADDR_WIDTH` (32), `DATA_WIDTH` (32), `RDATA_WIDTH` (32) and `RADDR_WIDTH` (5) in defines.v.

Ports:
- clk_i  input  1  clock; every register updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_int_i  input  1  interrupt/exception flush from the controller.
- mem_addr_i  input  32  byte address from EXE/MEM.
- mem_data_i  input  32  store data, LSB-justified.
- mem_we_i  input  1  store flag, informational only; the operation is decoded from mem_op_i.
- mem_op_i  input  4  operation: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW. Codes 9–15 are treated as NOP.
- reg_waddr_i / reg_we_i / reg_wdata_i  input  5/1/32  write-back fields from EXE/MEM.
- exception_i  input  32  exception vector from EXE/MEM.
- bus_req_o  output  1  bus request.
- bus_we_o  output  1  1 = write.
- bus_addr_o  output  32  word-aligned address (low 2 bits are 0).
- bus_sel_o  output  4  byte-lane enables.
- bus_wdata_o  output  32  lane-replicated store data.
- bus_ack_i  input  1  one-cycle completion strobe from the responder.
- bus_rdata_i  input  32  read word, valid in the cycle bus_ack_i is high.
- stall_req_o  output  1  pipeline stall request (combinational).
- reg_waddr_o / reg_we_o / reg_wdata_o  output  5/1/32  to MEM/WB.
- exception_o  output  32  exception vector to MEM/WB.

## Operation
- The state machine has three states: IDLE, BUSY and DONE.
- **IDLE:**
  - If mem_op_i is not NOP, flush_int_i is 0 and the access is not faulted (see Configuration), latch the bus fields and go to BUSY.
  - Otherwise, pass the write-back fields and exception_i straight through.
- **BUSY:**
  - bus_req_o is 1 and every bus field is held stable until bus_ack_i.
  - On bus_ack_i, register the formatted load result, clear req and go to DONE.
- **DONE:**
  - For a load, drive reg_wdata_o from the registered result; reg_waddr_o and reg_we_o pass through.
  - For a store, pass reg_* through.
  - Return to IDLE unconditionally.
- **stall_req_o** is 1 in BUSY. It is also 1 in IDLE while a request is being launched (non-NOP, unfaulted, no flush). It is 0 in DONE.
- **Byte lanes** (a = mem_addr_i[1:0]):
  - Byte access: sel = 1<<a; wdata = {4{data[7:0]}}.
  - Half access: sel = 0011 when a[1]=0, 1100 when a[1]=1; wdata = {2{data[15:0]}}.
  - Word access: sel = 1111; wdata = data.
  - Loads drive the same sel pattern with bus_we_o = 0.
- **Load formatting:** select the byte at rdata[8a+7:8a] or the half at rdata[16a[1]+15:16a[1]]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- **Flush:**
  - In IDLE, suppress the launch.
  - In BUSY, keep req asserted until ack (a request is never dropped), then go to DONE with reg_we_o forced to 0.
  - In DONE, force reg_we_o to 0.
- **Reset:** any state goes to IDLE. Reset is the only way to abandon an outstanding request; the responder is reset on the same reset.

## Timing
- **Reset values:**
  - bus_req_o 0, bus_we_o 0, bus_addr_o 0, bus_sel_o 0, bus_wdata_o 0.
  - stall_req_o 0 while rst_i is high.
  - Registered load result 0; state IDLE.
- **Launch:** the request is visible on the bus the cycle after the op appears at the inputs.
- **Minimum latency** (ack in the first BUSY cycle): one IDLE cycle, one BUSY cycle, then result valid in DONE, i.e. three cycles from op arrival. Each extra wait cycle on bus_ack_i adds one cycle.
- **Protocol violations:** bus_ack_i while bus_req_o is 0 is ignored. Back-to-back memory ops launch again in the IDLE cycle after DONE.
- **Reset during BUSY:** req drops in the cycle after the reset edge.

## Configuration
- **LSU_MISALIGN_EN defined:**
  - Misaligned accesses are detected: a half access with a[0]=1, or a word access with a≠0.
  - A misaligned access issues no bus request, raises no stall and forces reg_we_o to 0.
  - exception_o = exception_i with bit 4 set for a misaligned load or bit 6 set for a misaligned store.
- **LSU_MISALIGN_EN undefined:**
  - No detection. The access proceeds with sel/lanes computed from the aligned-down offset: half uses a[1], word uses 1111.
  - exception_o always equals exception_i.

## Test plan
- **SW:** SW addr 0x100, data 0xDEADBEEF, ack after 2 wait cycles → bus_addr_o 0x100, sel 1111, we 1; stall_req_o high for 4 cycles; no register write.
- **LB, negative byte:** rdata 0x80FF1234 at addr 0x203 → reg_wdata_o 0xFFFFFF80. The same access as LBU → 0x00000080.
- **SH at addr 0x2:** data 0x0000ABCD → sel 1100, wdata 0xABCDABCD.
- **Flush in BUSY:** assert flush_int_i in BUSY for an LW → req stays high until ack, then reg_we_o 0 in DONE, then IDLE.
- **LSU_MISALIGN_EN on, LW at 0x101:** → no bus_req_o, stall_req_o 0, exception_o bit 4 set, reg_we_o 0.
- **Reset mid-access:** rst_i in BUSY → next cycle bus_req_o 0, state IDLE, all bus outputs 0.
